// File: rtl/inst_port_arbiter.sv
// inst_port_arbiter: shares one combinational instruction-ROM port between the
// fetch stage (if_*) and code-space loads (dm_*). One grant per cycle, response
// captured at the grant edge and held until the requester accepts it.
// Build option: define INST_ARB_RR_EN for round-robin arbitration on conflict;
// the default build gives dm fixed priority.
module inst_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  // fetch-stage requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  input  logic        if_rdy,
  output logic [31:0] if_inst,
  // load-from-code-space requester
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  output logic        dm_gnt,
  output logic        dm_valid,
  input  logic        dm_rdy,
  output logic [31:0] dm_data,
  // shared ROM port
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  // pipeline stall
  output logic        stallreq_if
);

  logic        if_valid_q, if_valid_d;
  logic        dm_valid_q, dm_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] dm_data_q, dm_data_d;
  logic        if_elig, dm_elig;
  logic        dm_wins;

  // A requester may be granted when its response slot is empty or is being
  // drained in this same cycle.
  assign if_elig = if_req & (~if_valid_q | if_rdy);
  assign dm_elig = dm_req & (~dm_valid_q | dm_rdy);

`ifdef INST_ARB_RR_EN
  typedef enum logic [1:0] {IDLE, LAST_IF, LAST_DM} state_e;
  state_e state_q;

  // IDLE doubles as the round-robin pointer's "IF preferred" position, so only
  // a cycle that directly follows an IF grant hands a conflict to dm.
  assign dm_wins = (state_q == LAST_IF);

  // Track the most recently granted requester (IDLE after a grant-free cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else if (if_gnt) begin
      state_q <= LAST_IF;
    end else if (dm_gnt) begin
      state_q <= LAST_DM;
    end else begin
      state_q <= IDLE;
    end
  end
`else
  // Fixed priority: dm takes every conflict; a starved fetch shows on stallreq_if.
  assign dm_wins = 1'b1;
`endif

  // Grants are combinational and suppressed while reset is asserted.
  assign if_gnt = rst & if_elig & ~(dm_elig & dm_wins);
  assign dm_gnt = rst & dm_elig & ~(if_elig & ~dm_wins);

  assign rom_ce   = if_gnt | dm_gnt;
  assign rom_addr = if_gnt ? if_addr : (dm_gnt ? dm_addr : 32'h0);

  // Response slot next state: a grant refills (even while draining), an
  // accept without a grant empties, otherwise hold.
  always_comb begin
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    dm_valid_d = dm_valid_q;
    dm_data_d  = dm_data_q;
    if (if_gnt) begin
      if_valid_d = 1'b1;
      if_inst_d  = rom_inst;
    end else if (if_valid_q & if_rdy) begin
      if_valid_d = 1'b0;
    end
    if (dm_gnt) begin
      dm_valid_d = 1'b1;
      dm_data_d  = rom_inst;
    end else if (dm_valid_q & dm_rdy) begin
      dm_valid_d = 1'b0;
    end
  end

  // Response registers; reset discards anything not yet consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid_q <= 1'b0;
      if_inst_q  <= 32'h0;
      dm_valid_q <= 1'b0;
      dm_data_q  <= 32'h0;
    end else begin
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      dm_valid_q <= dm_valid_d;
      dm_data_q  <= dm_data_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign dm_valid = dm_valid_q;
  assign dm_data  = dm_data_q;

  assign stallreq_if = (if_req & ~if_gnt) | (if_valid_q & ~if_rdy);

endmodule
